stack_alu_sequencer: RTL and testbench

Token-stream controller that sequences one STACK_BASED_ALU instance. Accepts an RPN expression as push/add/mul/end tokens over a valid/ready interface and drives the ALU opcode and input_data. Tracks ALU stack depth to catch underflow and full-stack errors, accumulates a sticky overflow flag, and returns the popped result over a second valid/ready interface. Sits between the command source and the ALU; the ALU itself is unchanged.

---
 rtl/stack_seq_pkg.sv | 37 +++
 rtl/stack_seq_depth.sv | 48 ++++
 rtl/stack_alu_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_stack_alu_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_seq_pkg.sv
// ---------------------------------------------------------------------------
// stack_seq_pkg
// Shared definitions for the stack ALU sequencer:
//   - token-kind encodings carried on the token interface
//   - opcode constants driven to the STACK_BASED_ALU
//   - sequencer state enumeration
// Optional build macro: STACK_SEQ_FLUSH_EN adds the FLUSH state.
// ---------------------------------------------------------------------------
package stack_seq_pkg;

  // Token kinds
  localparam logic [1:0] TOK_PUSH = 2'b00;
  localparam logic [1:0] TOK_ADD  = 2'b01;
  localparam logic [1:0] TOK_MUL  = 2'b10;
  localparam logic [1:0] TOK_END  = 2'b11;

  // ALU opcodes
  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;

  typedef enum logic [2:0] {
    ST_ACCEPT,
    ST_ARITH_WAIT,
    ST_POP_WAIT,
    ST_DRAIN,
`ifdef STACK_SEQ_FLUSH_EN
    ST_RESULT,
    ST_FLUSH
`else
    ST_RESULT
`endif
  } state_e;

endpackage

// File: rtl/stack_seq_depth.sv
// ---------------------------------------------------------------------------
// stack_seq_depth
// Up/down counter mirroring the number of entries held in the ALU stack.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_inc / i_dec       count one push / one pop (inc wins if both)
//   i_clr               force the count to zero (highest priority)
//   o_depth             current entry count, 0..DEPTH
//   o_full/o_empty      depth == DEPTH / depth == 0
//   o_ge2               at least two entries (binary op allowed)
// ---------------------------------------------------------------------------
module stack_seq_depth #(
  parameter int DEPTH = 8,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  input  logic          i_clr,
  output logic [DW-1:0] o_depth,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_ge2
);

  logic [DW-1:0] r_depth;

  // Saturating guards keep the count inside 0..DEPTH even if a caller
  // requests an impossible step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth <= '0;
    end else if (i_clr) begin
      r_depth <= '0;
    end else if (i_inc && !o_full) begin
      r_depth <= r_depth + DW'(1);
    end else if (i_dec && !o_empty) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  assign o_depth = r_depth;
  assign o_full  = (r_depth == DW'(DEPTH));
  assign o_empty = (r_depth == '0);
  assign o_ge2   = (r_depth >= DW'(2));

endmodule

// File: rtl/stack_alu_sequencer.sv
// ---------------------------------------------------------------------------
// stack_alu_sequencer
// Feeds an RPN token stream (push/add/mul/end) into one STACK_BASED_ALU,
// tracks the ALU stack depth to detect underflow / full-stack errors,
// accumulates a sticky overflow flag and returns the popped result.
// Ports:
//   i_clk, i_rst_n                 clock shared with the ALU, async active-low reset
//   i_tok_valid/o_tok_ready        token handshake
//   i_tok_kind, i_tok_data         token kind and push operand
//   o_alu_opcode, o_alu_input_data ALU command (combinational from the token)
//   i_alu_output_data, i_alu_overflow  ALU responses
//   o_res_valid/i_res_ready        result handshake
//   o_res_data, o_res_overflow, o_res_error  result payload
//   o_busy                         high in every state except ACCEPT
// Optional build macro: STACK_SEQ_FLUSH_EN -- after reset, pop the ALU
// DEPTH times to discard stale entries before accepting tokens.
// ---------------------------------------------------------------------------
module stack_alu_sequencer
  import stack_seq_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_tok_valid,
  output logic         o_tok_ready,
  input  logic [1:0]   i_tok_kind,
  input  logic [N-1:0] i_tok_data,
  output logic [2:0]   o_alu_opcode,
  output logic [N-1:0] o_alu_input_data,
  input  logic [N-1:0] i_alu_output_data,
  input  logic         i_alu_overflow,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [N-1:0] o_res_data,
  output logic         o_res_overflow,
  output logic         o_res_error,
  output logic         o_busy
);

  localparam int DW = $clog2(DEPTH + 1);

`ifdef STACK_SEQ_FLUSH_EN
  localparam state_e RESET_STATE = ST_FLUSH;
`else
  localparam state_e RESET_STATE = ST_ACCEPT;
`endif

  state_e        r_state;
  state_e        w_state_next;
  logic          r_err;
  logic          r_ovf;
  logic [N-1:0]  r_res_data;

  logic [DW-1:0] w_depth;
  logic          w_full;
  logic          w_empty;
  logic          w_ge2;
  logic          w_inc;
  logic          w_dec;
  logic          w_clr;
  logic          w_err_set;
  logic          w_ovf_set;
  logic          w_res_load;
  logic          w_res_zero;
  logic          w_flags_clr;

`ifdef STACK_SEQ_FLUSH_EN
  logic [DW-1:0] r_flush_cnt;
`endif

  stack_seq_depth #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_depth (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .i_clr   (w_clr),
    .o_depth (w_depth),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_ge2   (w_ge2)
  );

  // Next-state and command decode. The ALU acts on the same edge as the
  // token handshake, so the opcode is decoded directly from the token.
  always_comb begin
    w_state_next = r_state;
    o_tok_ready  = 1'b0;
    o_alu_opcode = NOP;
    o_res_valid  = 1'b0;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    w_clr        = 1'b0;
    w_err_set    = 1'b0;
    w_ovf_set    = 1'b0;
    w_res_load   = 1'b0;
    w_res_zero   = 1'b0;
    w_flags_clr  = 1'b0;

    case (r_state)
      ST_ACCEPT: begin
        o_tok_ready = 1'b1;
        if (i_tok_valid) begin
          case (i_tok_kind)
            TOK_PUSH: begin
              // A full stack flags an error even after an earlier error.
              if (w_full) begin
                w_err_set = 1'b1;
              end else if (!r_err) begin
                o_alu_opcode = PUSH;
                w_inc        = 1'b1;
              end
            end
            TOK_ADD, TOK_MUL: begin
              if (!w_ge2) begin
                w_err_set = 1'b1;
              end else if (!r_err) begin
                o_alu_opcode = (i_tok_kind == TOK_ADD) ? ADD : MUL;
                w_dec        = 1'b1;
                w_state_next = ST_ARITH_WAIT;
              end
            end
            default: begin
              if (!r_err && (w_depth == DW'(1))) begin
                o_alu_opcode = POP;
                w_clr        = 1'b1;
                w_state_next = ST_POP_WAIT;
              end else begin
                w_err_set    = 1'b1;
                w_state_next = ST_DRAIN;
              end
            end
          endcase
        end
      end

      // The ALU overflow flag for the op issued last edge is valid now.
      ST_ARITH_WAIT: begin
        w_ovf_set    = i_alu_overflow;
        w_state_next = ST_ACCEPT;
      end

      ST_POP_WAIT: begin
        w_res_load   = 1'b1;
        w_state_next = ST_RESULT;
      end

      // Empty whatever the failed expression left behind, one pop per cycle.
      ST_DRAIN: begin
        if (!w_empty) begin
          o_alu_opcode = POP;
          w_dec        = 1'b1;
        end else begin
          w_res_zero   = 1'b1;
          w_state_next = ST_RESULT;
        end
      end

      ST_RESULT: begin
        o_res_valid = 1'b1;
        if (i_res_ready) begin
          w_flags_clr  = 1'b1;
          w_state_next = ST_ACCEPT;
        end
      end

`ifdef STACK_SEQ_FLUSH_EN
      ST_FLUSH: begin
        o_alu_opcode = POP;
        if (r_flush_cnt == DW'(DEPTH - 1)) begin
          w_state_next = ST_ACCEPT;
        end
      end
`endif

      default: begin
        w_state_next = ST_ACCEPT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= RESET_STATE;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_res_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_flags_clr) begin
        r_err <= 1'b0;
        r_ovf <= 1'b0;
      end else begin
        if (w_err_set) begin
          r_err <= 1'b1;
        end
        if (w_ovf_set) begin
          r_ovf <= 1'b1;
        end
      end
      if (w_res_load) begin
        r_res_data <= i_alu_output_data;
      end else if (w_res_zero) begin
        r_res_data <= '0;
      end
    end
  end

`ifdef STACK_SEQ_FLUSH_EN
  // Counts the flush pops issued so far.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flush_cnt <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_flush_cnt <= r_flush_cnt + DW'(1);
    end
  end
`endif

  assign o_alu_input_data = i_tok_data;
  assign o_res_data       = r_res_data;
  assign o_res_overflow   = r_ovf;
  assign o_res_error      = r_err;
  assign o_busy           = (r_state != ST_ACCEPT);

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_alu_sequencer
// Drives directed and random RPN expressions into stack_alu_sequencer,
// with a behavioural STACK_BASED_ALU attached to its ALU ports, and
// compares results, flags, latency and the ALU opcode stream against a
// stack-based reference evaluation of each expression.
// ---------------------------------------------------------------------------
module tb_stack_alu_sequencer;

  localparam int N     = 16;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         tokValid = 1'b0;
  logic         tokReady;
  logic [1:0]   tokKind = 2'b00;
  logic [N-1:0] tokData = '0;
  logic [2:0]   aluOpcode;
  logic [N-1:0] aluInputData;
  logic [N-1:0] aluOutputData = '0;
  logic         aluOverflow = 1'b0;
  logic         resValid;
  logic         resReady = 1'b0;
  logic [N-1:0] resData;
  logic         resOverflow;
  logic         resError;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stack_alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .i_clk             (clk),
    .i_rst_n           (rstN),
    .i_tok_valid       (tokValid),
    .o_tok_ready       (tokReady),
    .i_tok_kind        (tokKind),
    .i_tok_data        (tokData),
    .o_alu_opcode      (aluOpcode),
    .o_alu_input_data  (aluInputData),
    .i_alu_output_data (aluOutputData),
    .i_alu_overflow    (aluOverflow),
    .o_res_valid       (resValid),
    .i_res_ready       (resReady),
    .o_res_data        (resData),
    .o_res_overflow    (resOverflow),
    .o_res_error       (resError),
    .o_busy            (busy)
  );

  // Behavioural ALU: unbounded stack, logs every non-nop opcode it sees.
  logic signed [N-1:0] aluStack[$];
  logic [2:0]          opLog[$];
  logic signed [N-1:0] aluA, aluB;
  int                  aluR;

  always @(posedge clk) begin
    case (aluOpcode)
      3'b110: begin
        aluStack.push_back(aluInputData);
        opLog.push_back(aluOpcode);
      end
      3'b100, 3'b101: begin
        opLog.push_back(aluOpcode);
        if (aluStack.size() >= 2) begin
          aluB = aluStack.pop_back();
          aluA = aluStack.pop_back();
          aluR = (aluOpcode == 3'b100) ? (int'(aluA) + int'(aluB)) : (int'(aluA) * int'(aluB));
          aluOverflow <= (aluR > 32767) || (aluR < -32768);
          aluStack.push_back(aluR[N-1:0]);
        end
      end
      3'b111: begin
        opLog.push_back(aluOpcode);
        if (aluStack.size() > 0) aluOutputData <= aluStack.pop_back();
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Current expression and its reference outcome.
  logic [1:0]   tokKindQ[$];
  logic [N-1:0] tokDataQ[$];
  logic [2:0]   expOps[$];
  logic [N-1:0] expRes;
  logic         expOvf;
  logic         expErr;
  int           expLat;

  task automatic clearTok();
    tokKindQ.delete();
    tokDataQ.delete();
  endtask

  task automatic addTok(input logic [1:0] k, input logic [N-1:0] d);
    tokKindQ.push_back(k);
    tokDataQ.push_back(d);
  endtask

  // Evaluates the expression with an integer stack and the documented
  // error rules, producing the result, flags, ops and result latency.
  task automatic runModel();
    int stk[$];
    int a, b, r;
    logic [N-1:0] t;
    expOps.delete();
    expErr = 1'b0; expOvf = 1'b0; expRes = '0; expLat = 0;
    foreach (tokKindQ[i]) begin
      case (tokKindQ[i])
        2'b00: begin
          if (stk.size() == DEPTH) expErr = 1'b1;
          else if (!expErr) begin
            stk.push_back(int'($signed(tokDataQ[i])));
            expOps.push_back(3'b110);
          end
        end
        2'b01, 2'b10: begin
          if (stk.size() < 2) expErr = 1'b1;
          else if (!expErr) begin
            b = stk.pop_back();
            a = stk.pop_back();
            r = (tokKindQ[i] == 2'b01) ? a + b : a * b;
            if (r > 32767 || r < -32768) expOvf = 1'b1;
            t = r[N-1:0];
            stk.push_back(int'($signed(t)));
            expOps.push_back(tokKindQ[i] == 2'b01 ? 3'b100 : 3'b101);
          end
        end
        default: begin
          if (!expErr && stk.size() == 1) begin
            t = stk[0];
            expRes = t;
            expOps.push_back(3'b111);
            expLat = 1;
          end else begin
            expErr = 1'b1;
            expRes = '0;
            expLat = stk.size() + 1;
            repeat (stk.size()) expOps.push_back(3'b111);
          end
        end
      endcase
    end
  endtask

  // Offers one token from a negedge and returns at the negedge after acceptance.
  task automatic sendToken(input logic [1:0] k, input logic [N-1:0] d);
    int waitCycles = 0;
    tokValid = 1'b1; tokKind = k; tokData = d;
    while (!tokReady && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!tokReady) checkOutput("tok_ready timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    tokValid = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input int holdCycles);
    int n;
    logic [N-1:0] heldData;
    runModel();
    opLog.delete();
    foreach (tokKindQ[i]) sendToken(tokKindQ[i], tokDataQ[i]);
    n = 0;
    while (!resValid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " latency"}, n, expLat);
    checkOutput({name, " res_data"}, resData, expRes);
    checkOutput({name, " res_overflow"}, resOverflow, expOvf);
    checkOutput({name, " res_error"}, resError, expErr);
    heldData = resData;
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput($sformatf("%s hold%0d res_valid", name, h), resValid, 1'b1);
      checkOutput($sformatf("%s hold%0d res_data", name, h), resData, heldData);
      checkOutput($sformatf("%s hold%0d tok_ready", name, h), tokReady, 1'b0);
    end
    resReady = 1'b1;
    @(negedge clk);
    resReady = 1'b0;
    checkOutput({name, " busy after"}, busy, 1'b0);
    checkOutput({name, " res_valid after"}, resValid, 1'b0);
    checkOutput({name, " op count"}, opLog.size(), expOps.size());
    for (int i = 0; i < expOps.size() && i < opLog.size(); i++)
      checkOutput($sformatf("%s op%0d", name, i), opLog[i], expOps[i]);
  endtask

  task automatic genRandomExpr();
    int nPush, pushed, g, len, v;
    logic [N-1:0] d;
    clearTok();
    if ($urandom_range(3) == 0) begin
      len = $urandom_range(1, 11);
      for (int i = 0; i < len; i++) begin
        v = $urandom();
        d = v[N-1:0];
        addTok(($urandom_range(2) == 0) ? 2'($urandom_range(1, 2)) : 2'b00, d);
      end
    end else begin
      nPush = $urandom_range(1, 6);
      pushed = 0; g = 0;
      while (!(pushed == nPush && g == 1)) begin
        if (g < 2 || (pushed < nPush && $urandom_range(1) == 0)) begin
          v = ($urandom_range(1) == 0) ? int'($urandom()) : $urandom_range(0, 80) - 40;
          d = v[N-1:0];
          addTok(2'b00, d);
          pushed++; g++;
        end else begin
          addTok(2'($urandom_range(1, 2)), '0);
          g--;
        end
      end
    end
    addTok(2'b11, '0);
  endtask

  initial begin
    @(negedge clk);
    checkOutput("reset tok_ready", tokReady, 1'b1);
    checkOutput("reset alu_opcode", aluOpcode, 3'b000);
    checkOutput("reset res_valid", resValid, 1'b0);
    checkOutput("reset res_overflow", resOverflow, 1'b0);
    checkOutput("reset res_error", resError, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset res_data", resData, 16'h0000);
    rstN = 1'b1;
    @(negedge clk);

    clearTok(); addTok(2'b00, 16'd14); addTok(2'b00, 16'd77); addTok(2'b01, '0); addTok(2'b11, '0);
    applyStimulus("add14_77", 0);
    clearTok(); addTok(2'b00, 16'd200); addTok(2'b00, -16'sd60); addTok(2'b10, '0); addTok(2'b11, '0);
    applyStimulus("mul200_m60", 0);
    clearTok(); addTok(2'b00, 16'd30000); addTok(2'b00, 16'd30000); addTok(2'b01, '0); addTok(2'b11, '0);
    applyStimulus("add_ovf", 0);
    clearTok(); addTok(2'b00, 16'd5); addTok(2'b01, '0); addTok(2'b11, '0);
    applyStimulus("underflow", 3);
    clearTok();
    for (int i = 0; i <= DEPTH; i++) addTok(2'b00, 16'(i + 1));
    addTok(2'b11, '0);
    applyStimulus("full_stack", 0);
    clearTok(); addTok(2'b11, '0);
    applyStimulus("end_empty", 0);

    for (int e = 0; e < 40; e++) begin
      genRandomExpr();
      applyStimulus($sformatf("rand%0d", e), $urandom_range(0, 2));
    end

    // Reset in the middle of an expression with the overflow flag set.
    sendToken(2'b00, 16'd30000);
    sendToken(2'b00, 16'd30000);
    sendToken(2'b01, '0);
    sendToken(2'b00, 16'd3);
    checkOutput("midexpr ovf before reset", resOverflow, 1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("midreset tok_ready", tokReady, 1'b1);
    checkOutput("midreset alu_opcode", aluOpcode, 3'b000);
    checkOutput("midreset res_valid", resValid, 1'b0);
    checkOutput("midreset res_overflow", resOverflow, 1'b0);
    checkOutput("midreset res_error", resError, 1'b0);
    checkOutput("midreset busy", busy, 1'b0);
    checkOutput("midreset res_data", resData, 16'h0000);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    clearTok(); addTok(2'b00, 16'd7); addTok(2'b00, 16'd6); addTok(2'b10, '0); addTok(2'b11, '0);
    applyStimulus("after_reset", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
